fft_frame_ctrl: RTL
===================

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter FFT_SIZE, default 32, points per frame.
REQ-002 SHALL have parameter IN_W, default 12, input sample width per component.
REQ-003 SHALL have parameter OUT_W, default 16, output sample width per component.
REQ-004 SHALL have parameter LAT_LIMIT, default 68, maximum allowed idle-output cycles per frame.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1, reset (one clock; asynchronous, active-high).
REQ-007 SHALL have ports s_valid/s_ready, input/output, 1/1, upstream sample handshake.
REQ-008 SHALL have ports s_r/s_i, input, IN_W each, signed upstream sample.
REQ-009 SHALL have port fft_rst_n, output, 1, active-low reset to FFT core.
REQ-010 SHALL have ports fft_in_valid/fft_din_r/fft_din_i, output, 1/IN_W/IN_W, core input.
REQ-011 SHALL have ports fft_out_valid/fft_dout_r/fft_dout_i, input, 1/OUT_W/OUT_W, core output.
REQ-012 SHALL have ports m_valid/m_r/m_i, output, 1/OUT_W/OUT_W, downstream result; no backpressure.
REQ-013 SHALL have ports m_index/m_last, output, 5/1, bin number and last-bin flag.
REQ-014 SHALL have ports busy/timeout_err/err_clr/frame_cnt, out/out/in/out, 1/1/1/8.

Function
REQ-015 SHALL buffer upstream samples in a FFT_SIZE-entry FIFO; s_ready = (count < FFT_SIZE); write on s_valid&&s_ready.
REQ-016 SHALL use states IDLE, LOAD, WAIT, DRAIN, ERR, CORE_RST.
REQ-017 IDLE->LOAD SHALL occur when count == FFT_SIZE; no other IDLE exit except err path.
REQ-018 In LOAD, SHALL pop one entry per cycle and drive registered fft_in_valid=1 with that data for exactly FFT_SIZE consecutive cycles, then go to WAIT.
REQ-019 Simultaneous FIFO push and pop SHALL be allowed; count unchanged; samples pushed during LOAD/WAIT/DRAIN belong to the next frame.
REQ-020 fft_din_r/i SHALL hold last value when fft_in_valid=0.
REQ-021 Latency counter SHALL clear on entering WAIT and increment each WAIT cycle and each DRAIN cycle with fft_out_valid=0.
REQ-022 WAIT->DRAIN SHALL occur on first fft_out_valid=1; that sample is bin 0.
REQ-023 In DRAIN, each fft_out_valid=1 cycle SHALL produce m_valid=1 one cycle later with registered data, m_index incrementing from 0.
REQ-024 m_last SHALL be 1 only with m_index == FFT_SIZE-1; then state->IDLE and frame_cnt increments (wraps 255->0).
REQ-025 Latency counter > LAT_LIMIT SHALL move to ERR, set timeout_err (sticky), suppress m_valid.
REQ-026 In ERR, err_clr=1 SHALL flush FIFO, clear timeout_err, go CORE_RST: fft_rst_n=0 for 2 cycles, then IDLE.
REQ-027 fft_out_valid in IDLE, LOAD, ERR or CORE_RST SHALL be ignored.
REQ-028 err_clr outside ERR SHALL be ignored.
REQ-029 busy SHALL be 1 in every state except IDLE.

Reset
REQ-030 rst=1 SHALL asynchronously force IDLE, FIFO empty, s_ready=0 while rst high, fft_rst_n=0, fft_in_valid=0, fft_din=0, m_valid=0, m_r/m_i=0, m_index=0, m_last=0, timeout_err=0, frame_cnt=0, busy=0.
REQ-031 After rst deasserts, fft_rst_n SHALL stay 0 for 2 more cycles (CORE_RST path), then 1.
REQ-032 rst mid-frame SHALL discard all buffered and in-flight data with no m_valid emitted.

Verification
REQ-033 32 samples with s_valid gaps, core responds 20 cycles after load -> fft_in_valid high exactly 32 contiguous cycles; 32 m_valid, indices 0..31, m_last at 31, frame_cnt=1.
REQ-034 Two back-to-back 64-sample bursts -> s_ready drops at count 32, second LOAD starts the cycle after first m_last, frame_cnt=2.
REQ-035 Core never asserts fft_out_valid -> ERR after 69 WAIT cycles, timeout_err=1, no m_valid; err_clr -> fft_rst_n low 2 cycles, IDLE, FIFO empty.
REQ-036 Core outputs 16 bins, stalls 80 cycles -> timeout_err=1, m_valid stops at index 15.
REQ-037 rst asserted during LOAD cycle 10 -> all outputs at reset values immediately; new 32-sample frame afterwards processes normally.
REQ-038 Spurious fft_out_valid in IDLE -> no m_valid, frame_cnt unchanged.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// Frame controller around a streaming FFT core: buffers one frame of samples,
// feeds the core, collects and indexes its output, and recovers from core stalls.
module fft_frame_ctrl #(
  parameter int FFT_SIZE  = 32,
  parameter int IN_W      = 12,
  parameter int OUT_W     = 16,
  parameter int LAT_LIMIT = 68
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [IN_W-1:0]  s_r,
  input  logic signed [IN_W-1:0]  s_i,
  output logic                    fft_rst_n,
  output logic                    fft_in_valid,
  output logic signed [IN_W-1:0]  fft_din_r,
  output logic signed [IN_W-1:0]  fft_din_i,
  input  logic                    fft_out_valid,
  input  logic signed [OUT_W-1:0] fft_dout_r,
  input  logic signed [OUT_W-1:0] fft_dout_i,
  output logic                    m_valid,
  output logic signed [OUT_W-1:0] m_r,
  output logic signed [OUT_W-1:0] m_i,
  output logic [4:0]              m_index,
  output logic                    m_last,
  output logic                    busy,
  output logic                    timeout_err,
  input  logic                    err_clr,
  output logic [7:0]              frame_cnt
);

  localparam int PTR_W = (FFT_SIZE > 1) ? $clog2(FFT_SIZE) : 1;
  localparam int CNT_W = $clog2(FFT_SIZE + 1);
  localparam int LAT_W = $clog2(LAT_LIMIT + 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    DRAIN,
    ERR,
    CORE_RST
  } state_t;

  state_t                 r_state;
  logic [2*IN_W-1:0]      r_mem [FFT_SIZE];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [PTR_W-1:0]       r_ld_cnt;
  logic [PTR_W-1:0]       r_bin;
  logic [LAT_W-1:0]       r_lat;
  logic                   r_crst;
  logic                   r_fft_rst_n;
  logic                   r_fft_in_valid;
  logic signed [IN_W-1:0] r_fft_din_r;
  logic signed [IN_W-1:0] r_fft_din_i;
  logic                   r_m_valid;
  logic signed [OUT_W-1:0] r_m_r;
  logic signed [OUT_W-1:0] r_m_i;
  logic [4:0]             r_m_index;
  logic                   r_m_last;
  logic                   r_busy;
  logic                   r_timeout_err;
  logic [7:0]             r_frame_cnt;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_flush;
  logic [PTR_W-1:0]       w_wr_nxt;
  logic [PTR_W-1:0]       w_rd_nxt;
  logic [2*IN_W-1:0]      w_rd_data;
  logic [LAT_W-1:0]       w_lat_inc;
  logic                   w_lat_over;
  logic                   w_bin_last;
  logic                   w_ld_last;

  assign s_ready    = !rst && (r_count < CNT_W'(FFT_SIZE));
  assign w_push     = s_valid && s_ready;
  assign w_pop      = (r_state == LOAD);
  assign w_flush    = (r_state == ERR) && err_clr;
  assign w_wr_nxt   = (r_wr_ptr == PTR_W'(FFT_SIZE - 1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_nxt   = (r_rd_ptr == PTR_W'(FFT_SIZE - 1)) ? '0 : r_rd_ptr + 1'b1;
  assign w_rd_data  = r_mem[r_rd_ptr];
  assign w_lat_inc  = r_lat + 1'b1;
  assign w_lat_over = (w_lat_inc > LAT_W'(LAT_LIMIT));
  assign w_bin_last = (r_bin == PTR_W'(FFT_SIZE - 1));
  assign w_ld_last  = (r_ld_cnt == PTR_W'(FFT_SIZE - 1));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {s_r, s_i};
    end
  end

  // Push and pop may coincide in LOAD; pushed samples then belong to the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // fft_rst_n low while in IDLE marks a fresh reset: pass through CORE_RST first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_ld_cnt       <= '0;
      r_bin          <= '0;
      r_lat          <= '0;
      r_crst         <= 1'b0;
      r_fft_rst_n    <= 1'b0;
      r_fft_in_valid <= 1'b0;
      r_fft_din_r    <= '0;
      r_fft_din_i    <= '0;
      r_m_valid      <= 1'b0;
      r_m_r          <= '0;
      r_m_i          <= '0;
      r_m_index      <= '0;
      r_m_last       <= 1'b0;
      r_busy         <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_frame_cnt    <= '0;
    end else begin
      r_fft_in_valid <= 1'b0;
      r_m_valid      <= 1'b0;
      r_m_last       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_fft_rst_n) begin
            r_state <= CORE_RST;
            r_crst  <= 1'b0;
            r_busy  <= 1'b1;
          end else if (r_count == CNT_W'(FFT_SIZE)) begin
            r_state  <= LOAD;
            r_ld_cnt <= '0;
            r_busy   <= 1'b1;
          end
        end
        LOAD: begin
          r_fft_in_valid <= 1'b1;
          r_fft_din_r    <= w_rd_data[2*IN_W-1:IN_W];
          r_fft_din_i    <= w_rd_data[IN_W-1:0];
          r_ld_cnt       <= r_ld_cnt + 1'b1;
          if (w_ld_last) begin
            r_state <= WAIT;
            r_lat   <= '0;
          end
        end
        WAIT: begin
          if (fft_out_valid) begin
            r_m_valid <= 1'b1;
            r_m_r     <= fft_dout_r;
            r_m_i     <= fft_dout_i;
            r_m_index <= '0;
            r_bin     <= PTR_W'(1);
            r_state   <= DRAIN;
          end else begin
            r_lat <= w_lat_inc;
            if (w_lat_over) begin
              r_state       <= ERR;
              r_timeout_err <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (fft_out_valid) begin
            r_m_valid <= 1'b1;
            r_m_r     <= fft_dout_r;
            r_m_i     <= fft_dout_i;
            r_m_index <= 5'(r_bin);
            r_m_last  <= w_bin_last;
            r_bin     <= r_bin + 1'b1;
            if (w_bin_last) begin
              r_state     <= IDLE;
              r_busy      <= 1'b0;
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end else begin
            r_lat <= w_lat_inc;
            if (w_lat_over) begin
              r_state       <= ERR;
              r_timeout_err <= 1'b1;
            end
          end
        end
        ERR: begin
          if (err_clr) begin
            r_timeout_err <= 1'b0;
            r_fft_rst_n   <= 1'b0;
            r_crst        <= 1'b0;
            r_state       <= CORE_RST;
          end
        end
        CORE_RST: begin
          if (r_crst) begin
            r_state     <= IDLE;
            r_fft_rst_n <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_crst <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fft_rst_n    = r_fft_rst_n;
  assign fft_in_valid = r_fft_in_valid;
  assign fft_din_r    = r_fft_din_r;
  assign fft_din_i    = r_fft_din_i;
  assign m_valid      = r_m_valid;
  assign m_r          = r_m_r;
  assign m_i          = r_m_i;
  assign m_index      = r_m_index;
  assign m_last       = r_m_last;
  assign busy         = r_busy;
  assign timeout_err  = r_timeout_err;
  assign frame_cnt    = r_frame_cnt;

endmodule
